// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Contents:
//   - A_NOP..A_LUI : 5-bit ALU opcodes
//   - PORT_EX      : port 0, the pipeline EX stage
//   - PORT_AUX     : port 1, the multi-cycle address/iteration engine
package alu_pkg;

    localparam logic [4:0] A_NOP  = 5'h00;
    localparam logic [4:0] A_ADD  = 5'h01;
    localparam logic [4:0] A_SUB  = 5'h02;
    localparam logic [4:0] A_AND  = 5'h03;
    localparam logic [4:0] A_OR   = 5'h04;
    localparam logic [4:0] A_XOR  = 5'h05;
    localparam logic [4:0] A_NOR  = 5'h06;
    localparam logic [4:0] A_ADDU = 5'h07;
    localparam logic [4:0] A_SUBU = 5'h08;
    localparam logic [4:0] A_SLL  = 5'h09;
    localparam logic [4:0] A_SRA  = 5'h0A;
    localparam logic [4:0] A_SRL  = 5'h0B;
    localparam logic [4:0] A_SLT  = 5'h0C;
    localparam logic [4:0] A_SLTU = 5'h0D;
    localparam logic [4:0] A_LUI  = 5'h0E;

    localparam logic PORT_EX  = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Ports:
//   alu_a   : operand A (shift amount for shifts, low 5 bits used)
//   alu_b   : operand B (value being shifted for shifts)
//   alu_op  : 5-bit opcode from alu_pkg; unknown codes give 0
//   alu_out : result; no overflow detection
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [4:0]  alu_op,
    output logic [31:0] alu_out
);

    // Opcode decode; signed and unsigned add/sub share the same adder.
    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            A_NOP:          alu_out = 32'd0;
            A_ADD, A_ADDU:  alu_out = alu_a + alu_b;
            A_SUB, A_SUBU:  alu_out = alu_a - alu_b;
            A_AND:          alu_out = alu_a & alu_b;
            A_OR:           alu_out = alu_a | alu_b;
            A_XOR:          alu_out = alu_a ^ alu_b;
            A_NOR:          alu_out = ~(alu_a | alu_b);
            A_SLL:          alu_out = alu_b << alu_a[4:0];
            A_SRA:          alu_out = $signed(alu_b) >>> alu_a[4:0];
            A_SRL:          alu_out = alu_b >> alu_a[4:0];
            A_SLT:          alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            A_SLTU:         alu_out = {31'd0, (alu_a < alu_b)};
            A_LUI:          alu_out = {alu_b[15:0], 16'h0000};
            default:        alu_out = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and
// returns results through a single registered response channel tagged
// with the originating port. One operation per cycle, one cycle latency.
// Parameters:
//   RR_EN : 1 = round-robin on contention, 0 = port 0 always wins
//   TAG_W : width of the opaque tag echoed with each result
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready         : request handshake for port N
//   reqN_op/a/b/tag          : opcode, operands and tag for port N
//   rsp_valid/ready          : response handshake
//   rsp_port/tag/data        : originating port, tag and ALU result
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_port,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data
);

    logic             rsp_valid_r;
    logic             rsp_port_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic [31:0]      rsp_data_r;
    logic             last_grant_r;

    logic             can_accept_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             transfer_s;
    logic [4:0]       mux_op_s;
    logic [31:0]      mux_a_s;
    logic [31:0]      mux_b_s;
    logic [TAG_W-1:0] mux_tag_s;
    logic [31:0]      alu_out_s;

    // Result register frees up when empty or being drained this cycle.
    assign can_accept_s = ~rsp_valid_r | rsp_ready;

    // Grant selection; on contention round-robin hands the slot to the port
    // that did not win the last transfer.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (RR_EN && (last_grant_r == PORT_EX)) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s & can_accept_s;
    assign req1_ready = grant1_s & can_accept_s;
    assign transfer_s = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Operand/op/tag mux steered by the grant.
    always_comb begin
        mux_op_s  = req0_op;
        mux_a_s   = req0_a;
        mux_b_s   = req0_b;
        mux_tag_s = req0_tag;
        if (grant1_s) begin
            mux_op_s  = req1_op;
            mux_a_s   = req1_a;
            mux_b_s   = req1_b;
            mux_tag_s = req1_tag;
        end else begin
            mux_op_s  = req0_op;
            mux_a_s   = req0_a;
            mux_b_s   = req0_b;
            mux_tag_s = req0_tag;
        end
    end

    alu_share_arbiter_alu u_alu (
        .alu_a   (mux_a_s),
        .alu_b   (mux_b_s),
        .alu_op  (mux_op_s),
        .alu_out (alu_out_s)
    );

    // Response register and priority state; priority only rotates on a
    // real transfer, so idle and stalled cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_port_r   <= PORT_EX;
            rsp_tag_r    <= '0;
            rsp_data_r   <= 32'd0;
            last_grant_r <= PORT_AUX;
        end else if (transfer_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_port_r   <= grant1_s ? PORT_AUX : PORT_EX;
            rsp_tag_r    <= mux_tag_s;
            rsp_data_r   <= alu_out_s;
            last_grant_r <= grant1_s ? PORT_AUX : PORT_EX;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_port  = rsp_port_r;
    assign rsp_tag   = rsp_tag_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter. A round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_port;
    logic [3:0]  rr_rsp_tag;
    logic [31:0] rr_rsp_data;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_port;
    logic [3:0]  fp_rsp_tag;
    logic [31:0] fp_rsp_data;

    int n_cmp;
    int n_err;

    alu_share_arbiter #(.RR_EN(1'b1), .TAG_W(4)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rr_rsp_port),
        .rsp_tag(rr_rsp_tag), .rsp_data(rr_rsp_data)
    );

    alu_share_arbiter #(.RR_EN(1'b0), .TAG_W(4)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_port(fp_rsp_port),
        .rsp_tag(fp_rsp_tag), .rsp_data(fp_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_chk(input string name, input logic port, input logic [3:0] tag,
                           input logic [31:0] data);
        chk({name, ".valid"}, {31'd0, rr_rsp_valid}, 32'd1);
        chk({name, ".port"},  {31'd0, rr_rsp_port}, {31'd0, port});
        chk({name, ".tag"},   {28'd0, rr_rsp_tag}, {28'd0, tag});
        chk({name, ".data"},  rr_rsp_data, data);
    endtask

    // One op issued on port 1, checked on the following cycle.
    task automatic issue1(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
        req1_valid = 1'b1;
        req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
        #1;
        chk({name, ".ready"}, {31'd0, rr_req1_ready}, 32'd1);
        tick();
        rsp_chk(name, 1'b1, tag, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'h3;
        req1_valid = 1'b0; req1_op = 5'h00; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'h0;

        // Reset held two cycles, request waiting.
        tick();
        chk("rst_valid_c1", {31'd0, rr_rsp_valid}, 32'd0);
        tick();
        chk("rst_valid_c2", {31'd0, rr_rsp_valid}, 32'd0);
        chk("rst_data", rr_rsp_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, rr_req0_ready}, 32'd1);
        tick();
        rsp_chk("single_add", 1'b0, 4'h3, 32'd12);
        req0_valid = 1'b0;

        // Op coverage on port 1, back to back.
        issue1("sll",  5'h09, 32'd4,        32'd1,          4'h1, 32'd16);
        issue1("sra",  5'h0A, 32'd4,        32'h8000_0000,  4'h2, 32'hF800_0000);
        issue1("slt",  5'h0C, 32'hFFFF_FFFF, 32'd1,         4'h3, 32'd1);
        issue1("sltu", 5'h0D, 32'hFFFF_FFFF, 32'd1,         4'h4, 32'd0);
        issue1("lui",  5'h0E, 32'd0,        32'h0000_1234,  4'h5, 32'h1234_0000);
        issue1("bad",  5'h1F, 32'd9,        32'd9,          4'h6, 32'd0);
        req1_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, rr_rsp_valid}, 32'd0);

        // Round-robin contention: port 0 first, then alternate.
        req0_valid = 1'b1; req0_op = 5'h02; req0_a = 32'd10;   req0_b = 32'd3;    req0_tag = 4'h1;
        req1_valid = 1'b1; req1_op = 5'h04; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_tag = 4'h2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", {31'd0, rr_req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, rr_req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (i % 2 == 0) rsp_chk("rr_p0", 1'b0, 4'h1, 32'd7);
            else            rsp_chk("rr_p1", 1'b1, 4'h2, 32'hFF);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Back-pressure: 12 pending, stalled three cycles, then drain+accept.
        req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'h5;
        tick();
        rsp_chk("bp_first", 1'b0, 4'h5, 32'd12);
        rsp_ready = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_tag = 4'h6;
        req1_valid = 1'b1; req1_op = 5'h01; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'h7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", {31'd0, rr_req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, rr_req1_ready}, 32'd0);
            tick();
            rsp_chk("bp_hold", 1'b0, 4'h5, 32'd12);
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready0", {31'd0, rr_req0_ready}, 32'd1);
        tick();
        rsp_chk("bp_next", 1'b0, 4'h6, 32'd3);
        req0_valid = 1'b0;
        tick();
        chk("bp_drained", {31'd0, rr_rsp_valid}, 32'd0);

        // Reset with a stalled result; last grant was port 0 beforehand.
        req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd2; req0_b = 32'd2; req0_tag = 4'h7;
        tick();
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        rsp_chk("mid_pending", 1'b0, 4'h7, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, rr_rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 5'h03; req0_a = 32'hFF; req0_b = 32'h0F; req0_tag = 4'h8;
        req1_valid = 1'b1; req1_op = 5'h05; req1_a = 32'hFF; req1_b = 32'h0F; req1_tag = 4'h9;
        #1;
        chk("mid_ready0", {31'd0, rr_req0_ready}, 32'd1);
        chk("mid_ready1", {31'd0, rr_req1_ready}, 32'd0);
        tick();
        rsp_chk("mid_grant", 1'b0, 4'h8, 32'h0F);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Fixed priority: both ports always valid, port 1 never granted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fp_ready1", {31'd0, fp_req1_ready}, 32'd0);
            tick();
            chk("fp_valid", {31'd0, fp_rsp_valid}, 32'd1);
            chk("fp_port", {31'd0, fp_rsp_port}, 32'd0);
            chk("rr_alt_port", {31'd0, rr_rsp_port}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
